// File: rtl/ws2812_bit_encoder.sv
// WS2812 NRZ serializer: takes 24-bit GRB pixels over valid/ready and drives sdi,
// inserting the latch low period on request. Optional pixel counter: WS2812_ENC_PIXEL_COUNT_EN.
module ws2812_bit_encoder #(
  parameter int T_BIT      = 25,
  parameter int T0H        = 8,
  parameter int T1H        = 16,
  parameter int T_RESET    = 1200,
  parameter int PIXEL_BITS = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  input  logic                  latch_req,
  output logic                  busy,
  output logic                  sdi
`ifdef WS2812_ENC_PIXEL_COUNT_EN
  ,
  output logic [15:0]           pixel_count
`endif
);

  localparam int MAXT = (T_BIT > T_RESET) ? T_BIT : T_RESET;
  localparam int PW   = $clog2(MAXT);
  localparam int BW   = $clog2(PIXEL_BITS);

  localparam logic [PW-1:0] T0H_LAST   = PW'(T0H - 1);
  localparam logic [PW-1:0] T1H_LAST   = PW'(T1H - 1);
  localparam logic [PW-1:0] T0L_LAST   = PW'(T_BIT - T0H - 1);
  localparam logic [PW-1:0] T1L_LAST   = PW'(T_BIT - T1H - 1);
  localparam logic [PW-1:0] RESET_LAST = PW'(T_RESET - 1);
  localparam logic [BW-1:0] BIT_FIRST  = BW'(PIXEL_BITS - 1);

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
    $error("ws2812_bit_encoder: timing parameters must satisfy 0 < T0H < T1H < T_BIT");
  end

  typedef enum logic [1:0] {IDLE, BIT_HIGH, BIT_LOW, LATCH} state_t;

  state_t                  state_q, state_d;
  logic [PIXEL_BITS-1:0]   shift_q, shift_d;
  logic [BW-1:0]           bit_idx_q, bit_idx_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic                    latch_pending_q, latch_pending_d;
  logic                    sdi_q, sdi_d;
  logic                    cur_bit, high_last, low_last, accept, latch_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      shift_q         <= '0;
      bit_idx_q       <= '0;
      phase_q         <= '0;
      latch_pending_q <= 1'b0;
      sdi_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_idx_q       <= bit_idx_d;
      phase_q         <= phase_d;
      latch_pending_q <= latch_pending_d;
      sdi_q           <= sdi_d;
    end
  end

  // The ready window on the last low cycle of bit 0 lets a new pixel follow with no gap.
  always_comb begin
    cur_bit   = shift_q[PIXEL_BITS-1];
    high_last = (phase_q == (cur_bit ? T1H_LAST : T0H_LAST));
    low_last  = (phase_q == (cur_bit ? T1L_LAST : T0L_LAST));

    pixel_ready = 1'b0;
    if (!reset) begin
      if (state_q == IDLE)
        pixel_ready = 1'b1;
      else if (state_q == BIT_LOW && low_last && bit_idx_q == '0 && !latch_pending_q)
        pixel_ready = 1'b1;
    end
    accept = pixel_valid && pixel_ready;

    state_d         = state_q;
    shift_d         = shift_q;
    bit_idx_d       = bit_idx_q;
    phase_d         = phase_q + 1'b1;
    latch_pending_d = latch_pending_q;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (accept) begin
          shift_d   = pixel_data;
          bit_idx_d = BIT_FIRST;
          state_d   = BIT_HIGH;
          if (latch_req) latch_pending_d = 1'b1;
        end else if (latch_req) begin
          state_d = LATCH;
        end
      end
      BIT_HIGH: begin
        if (latch_req) latch_pending_d = 1'b1;
        if (high_last) begin
          state_d = BIT_LOW;
          phase_d = '0;
        end
      end
      BIT_LOW: begin
        if (latch_req) latch_pending_d = 1'b1;
        if (low_last) begin
          phase_d = '0;
          if (bit_idx_q != '0) begin
            bit_idx_d = bit_idx_q - 1'b1;
            shift_d   = {shift_q[PIXEL_BITS-2:0], 1'b0};
            state_d   = BIT_HIGH;
          end else if (accept) begin
            shift_d   = pixel_data;
            bit_idx_d = BIT_FIRST;
            state_d   = BIT_HIGH;
          end else if (latch_pending_q || latch_req) begin
            state_d = LATCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LATCH: begin
        if (phase_q == RESET_LAST) begin
          state_d = IDLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    latch_entry = (state_d == LATCH) && (state_q != LATCH);
    if (latch_entry) latch_pending_d = 1'b0;

    sdi_d = (state_d == BIT_HIGH);
  end

  assign busy = (state_q != IDLE) || latch_pending_q;
  assign sdi  = sdi_q;

`ifdef WS2812_ENC_PIXEL_COUNT_EN
  logic [15:0] pixel_count_q;

  always_ff @(posedge clk) begin
    if (reset || latch_entry)
      pixel_count_q <= '0;
    else if (accept)
      pixel_count_q <= pixel_count_q + 16'd1;
  end

  assign pixel_count = pixel_count_q;
`endif

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Directed self-checking bench for ws2812_bit_encoder; expected sdi waveforms come from
// the 25-cycle bit model (16 high for '1', 8 high for '0').
module tb_ws2812_bit_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic        latch_req = 1'b0;
  logic        busy;
  logic        sdi;
`ifdef WS2812_ENC_PIXEL_COUNT_EN
  logic [15:0] pixel_count;
`endif

  int checks = 0;
  int passes = 0;

  ws2812_bit_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .latch_req   (latch_req),
    .busy        (busy),
    .sdi         (sdi)
`ifdef WS2812_ENC_PIXEL_COUNT_EN
    ,
    .pixel_count (pixel_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Samples sdi against the bit model, one sample per cycle starting with the first high cycle.
  task automatic collectWave(input logic [47:0] bits, input int nSamples, input int latchAt,
                             output int bad, output int readyHits, output int busyLow);
    bad = 0;
    readyHits = 0;
    busyLow = 0;
    for (int k = 0; k < nSamples; k++) begin
      int   b;
      int   pos;
      int   high;
      logic expSdi;
      b      = k / 25;
      pos    = k % 25;
      high   = bits[47-b] ? 16 : 8;
      expSdi = (pos < high);
      if (sdi !== expSdi) bad++;
      if (pixel_ready === 1'b1) readyHits++;
      if (busy !== 1'b1) busyLow++;
      if (k == latchAt) latch_req = 1'b1;
      tick;
      latch_req = 1'b0;
      if (k == 599) pixel_valid = 1'b0;
    end
  endtask

  task automatic collectLatch(input int pulseAt, output int sdiHigh, output int readyHigh,
                              output int busyLow);
    sdiHigh = 0;
    readyHigh = 0;
    busyLow = 0;
    for (int j = 0; j < 1200; j++) begin
      if (sdi !== 1'b0) sdiHigh++;
      if (pixel_ready !== 1'b0) readyHigh++;
      if (busy !== 1'b1) busyLow++;
      if (j == pulseAt) latch_req = 1'b1;
      tick;
      latch_req = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++; if (sdi !== 1'b0) $display("[TB] FAIL reset_sdi: got %b expected 0", sdi); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (pixel_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", pixel_ready); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (pixel_ready !== 1'b1) $display("[TB] FAIL idle_ready: got %b expected 1", pixel_ready); else passes++;
    tick;
  endtask

  task automatic test_single_pixel;
    int bad, rh, bl;
    pixel_data  = 24'hFF0000;
    pixel_valid = 1'b1;
    #1;
    checks++; if (sdi !== 1'b0) $display("[TB] FAIL single_sdi_pre: got %b expected 0", sdi); else passes++;
    tick;
    pixel_valid = 1'b0;
    collectWave({24'hFF0000, 24'h0}, 600, -1, bad, rh, bl);
    checks++; if (bad !== 0) $display("[TB] FAIL single_wave: got %0d bad cycles expected 0", bad); else passes++;
    checks++; if (rh !== 1) $display("[TB] FAIL single_ready_cycles: got %0d expected 1", rh); else passes++;
    checks++; if (bl !== 0) $display("[TB] FAIL single_busy: got %0d idle cycles expected 0", bl); else passes++;
    checks++; if (pixel_ready !== 1'b1) $display("[TB] FAIL single_ready_end: got %b expected 1", pixel_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_end: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_back_to_back;
    int bad, rh, bl;
    pixel_data  = 24'hA5A5A5;
    pixel_valid = 1'b1;
    tick;
    pixel_data  = 24'h5A5A5A;
    collectWave({24'hA5A5A5, 24'h5A5A5A}, 1200, -1, bad, rh, bl);
    checks++; if (bad !== 0) $display("[TB] FAIL b2b_wave: got %0d bad cycles expected 0", bad); else passes++;
    checks++; if (rh !== 2) $display("[TB] FAIL b2b_ready_cycles: got %0d expected 2", rh); else passes++;
    checks++; if (bl !== 0) $display("[TB] FAIL b2b_busy: got %0d idle cycles expected 0", bl); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_busy_end: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_latch_mid_pixel;
    int bad, rh, bl, sh, lr, lb;
    pixel_data  = 24'h000001;
    pixel_valid = 1'b1;
    tick;
    pixel_valid = 1'b0;
    collectWave({24'h000001, 24'h0}, 600, 99, bad, rh, bl);
    checks++; if (bad !== 0) $display("[TB] FAIL latchmid_wave: got %0d bad cycles expected 0", bad); else passes++;
    checks++; if (rh !== 0) $display("[TB] FAIL latchmid_ready: got %0d ready cycles expected 0", rh); else passes++;
    checks++; if (bl !== 0) $display("[TB] FAIL latchmid_busy: got %0d idle cycles expected 0", bl); else passes++;
    collectLatch(-1, sh, lr, lb);
    checks++; if (sh !== 0) $display("[TB] FAIL latchmid_latch_sdi: got %0d high cycles expected 0", sh); else passes++;
    checks++; if (lr !== 0) $display("[TB] FAIL latchmid_latch_ready: got %0d ready cycles expected 0", lr); else passes++;
    checks++; if (lb !== 0) $display("[TB] FAIL latchmid_latch_busy: got %0d idle cycles expected 0", lb); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL latchmid_busy_end: got %b expected 0", busy); else passes++;
    checks++; if (pixel_ready !== 1'b1) $display("[TB] FAIL latchmid_ready_end: got %b expected 1", pixel_ready); else passes++;
  endtask

  task automatic test_simultaneous;
    int bad, rh, bl, sh, lr, lb;
    pixel_data  = 24'h123456;
    pixel_valid = 1'b1;
    latch_req   = 1'b1;
    tick;
    pixel_valid = 1'b0;
    latch_req   = 1'b0;
    collectWave({24'h123456, 24'h0}, 600, -1, bad, rh, bl);
    checks++; if (bad !== 0) $display("[TB] FAIL simul_wave: got %0d bad cycles expected 0", bad); else passes++;
    checks++; if (rh !== 0) $display("[TB] FAIL simul_ready: got %0d ready cycles expected 0", rh); else passes++;
    collectLatch(500, sh, lr, lb);
    checks++; if (sh !== 0) $display("[TB] FAIL simul_latch_sdi: got %0d high cycles expected 0", sh); else passes++;
    checks++; if (lb !== 0) $display("[TB] FAIL simul_latch_busy: got %0d idle cycles expected 0", lb); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL simul_not_extended: got busy %b expected 0", busy); else passes++;
  endtask

  task automatic test_reset_mid_pixel;
    int bad, rh, bl;
    pixel_data  = 24'hABCDEF;
    pixel_valid = 1'b1;
    tick;
    pixel_valid = 1'b0;
    collectWave({24'hABCDEF, 24'h0}, 300, 100, bad, rh, bl);
    checks++; if (bad !== 0) $display("[TB] FAIL rstmid_partial_wave: got %0d bad cycles expected 0", bad); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (pixel_ready !== 1'b0) $display("[TB] FAIL rstmid_ready_in_reset: got %b expected 0", pixel_ready); else passes++;
    tick;
    checks++; if (sdi !== 1'b0) $display("[TB] FAIL rstmid_sdi: got %b expected 0", sdi); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); else passes++;
    tick;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_pending_dropped: got busy %b expected 0", busy); else passes++;
    pixel_data  = 24'h00FF00;
    pixel_valid = 1'b1;
    tick;
    pixel_valid = 1'b0;
    collectWave({24'h00FF00, 24'h0}, 600, -1, bad, rh, bl);
    checks++; if (bad !== 0) $display("[TB] FAIL rstmid_new_wave: got %0d bad cycles expected 0", bad); else passes++;
    checks++; if (rh !== 1) $display("[TB] FAIL rstmid_new_ready: got %0d expected 1", rh); else passes++;
  endtask

`ifdef WS2812_ENC_PIXEL_COUNT_EN
  task automatic test_pixel_count;
    int accepted;
    int waited;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    checks++; if (pixel_count !== 16'd0) $display("[TB] FAIL count_reset: got %0d expected 0", pixel_count); else passes++;
    accepted    = 0;
    pixel_data  = 24'h0F0F0F;
    pixel_valid = 1'b1;
    for (int c = 0; c < 8000 && accepted < 12; c++) begin
      if (pixel_valid && pixel_ready) accepted++;
      tick;
      if (accepted == 12) pixel_valid = 1'b0;
    end
    pixel_valid = 1'b0;
    checks++; if (pixel_count !== 16'd12) $display("[TB] FAIL count_value: got %0d expected 12", pixel_count); else passes++;
    latch_req = 1'b1;
    tick;
    latch_req = 1'b0;
    waited = 0;
    while (pixel_count !== 16'd0 && waited < 700) begin
      tick;
      waited++;
    end
    checks++; if (pixel_count !== 16'd0) $display("[TB] FAIL count_latch_clear: got %0d expected 0", pixel_count); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL count_in_latch: got busy %b expected 1", busy); else passes++;
    waited = 0;
    while (busy !== 1'b0 && waited < 1300) begin
      tick;
      waited++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_pixel;
    test_back_to_back;
    test_latch_mid_pixel;
    test_simultaneous;
    test_reset_mid_pixel;
`ifdef WS2812_ENC_PIXEL_COUNT_EN
    test_pixel_count;
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
